// File: rtl/mux_nx1_stream.sv
// N-to-1 packet-aware stream multiplexer: explicit or round-robin channel choice,
// selection held for a whole packet, one registered output stage with valid/ready.
//
// state | meaning
// IDLE  | no packet in progress; channel chosen by s (mode 0) or round-robin (mode 1)
// LOCK  | packet in progress on lock_ch; mode and s ignored until its last beat
module mux_nx1_stream #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SW-1:0]   s,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_ch,
    output logic            locked
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]    state;
    logic [SW-1:0] lock_ch;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] rr_sel;
    logic          rr_found;
    logic [SW-1:0] sel;
    logic          sel_ok;
    logic          sel_valid;
    logic          sel_last;
    logic [W-1:0]  sel_data;
    logic          ld;
    logic          accept;

    // (a + k) mod N for channel indices, valid for any N, not just powers of two
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input int k);
        int t;
        t = int'(a) + k;
        if (t >= N) t = t - N;
        return SW'(t);
    endfunction

    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!rr_found && in_valid[wrap_add(rr_ptr, k)]) begin
                rr_found = 1'b1;
                rr_sel   = wrap_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        if (state == LOCK) begin
            sel    = lock_ch;
            sel_ok = 1'b1;
        end else if (mode) begin
            sel    = rr_sel;
            sel_ok = rr_found;
        end else begin
            sel    = s;
            sel_ok = (int'(s) < N);
        end
    end

    assign ld = !out_valid || out_ready;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (SW'(i) == sel) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i*W +: W];
                in_ready[i] = ld && sel_ok;
            end
        end
    end

    assign accept = ld && sel_ok && sel_valid;
    assign locked = (state == LOCK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lock_ch   <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_ch    <= sel;
                if (sel_last) begin
                    state  <= IDLE;
                    rr_ptr <= wrap_add(sel, 1);
                end else if (state == IDLE) begin
                    state   <= LOCK;
                    lock_ch <= sel;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
